// File: rtl/syn_vga_pkg.sv
// Shared types for the VGA line buffer: pixel type, line-buffer FSM states
// and the occupancy-counter width helper.
package syn_vga_pkg;

  localparam int PXL_W_DFLT = 16;
  localparam int DEPTH_DFLT = 1024;

  typedef logic [PXL_W_DFLT-1:0] pxl_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PREFILL = 2'd1,
    STREAM  = 2'd2
  } vga_lb_state_t;

  // Occupancy must represent 0..DEPTH inclusive, hence DEPTH+1 codes.
  function automatic int occ_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  localparam int OCC_W_DFLT = occ_w(DEPTH_DFLT);

endpackage

// File: rtl/syn_vga_line_bffr_ram.sv
// Simple dual-port pixel store: one write port, one registered read port.
module syn_vga_line_bffr_ram #(
  parameter int PXL_W = 16,
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk_ir,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [PXL_W-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [PXL_W-1:0] rd_data
);

  logic [PXL_W-1:0] mem_r [DEPTH];

  // Storage array and registered read; contents are not reset.
  always_ff @(posedge clk_ir) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem_r[rd_addr];
    end
  end

endmodule

// File: rtl/syn_vga_line_bffr.sv
// Pixel line buffer between the render path and the VGA driver, with a
// prefill FSM, occupancy output and sticky overflow/underflow status.
module syn_vga_line_bffr
  import syn_vga_pkg::*;
#(
  parameter int               PXL_W        = 16,
  parameter int               DEPTH        = 1024,
  parameter int               PREFILL_LVL  = 640,
  parameter int               BACKPRESSURE = 1,
  parameter logic [PXL_W-1:0] BLANK_PXL    = {PXL_W{1'b0}}
) (
  input  logic                        clk_ir,
  input  logic                        rst_ih,
  input  logic                        vga_drvr_en,
  input  logic                        wr_pxl_valid,
  input  logic [PXL_W-1:0]            wr_pxl_data,
  output logic                        wr_pxl_ready,
  input  logic                        rd_pxl_req,
  output logic                        rd_pxl_valid,
  output logic [PXL_W-1:0]            rd_pxl_data,
  output logic                        bffr_rdy,
  output logic [$clog2(DEPTH+1)-1:0]  bffr_occ,
  output logic                        bffr_overflow,
  output logic                        bffr_underflow,
  input  logic                        sts_clr
);

  localparam int AW    = $clog2(DEPTH);
  localparam int OCC_W = occ_w(DEPTH);

  vga_lb_state_t    state_r;
  vga_lb_state_t    state_nxt_s;
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [OCC_W-1:0] occ_r;
  logic             not_full_s;
  logic             wr_acc_s;
  logic             rd_req_s;
  logic             pop_s;
  logic             ovf_evt_s;
  logic             udf_evt_s;
  logic             rd_valid_r;
  logic             rd_hit_r;
  logic             ovf_r;
  logic             udf_r;
  logic [PXL_W-1:0] ram_q_s;

  // FSM state register.
  always_ff @(posedge clk_ir) begin
    if (rst_ih) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state: enable low forces IDLE from any state.
  always_comb begin
    state_nxt_s = state_r;
    if (!vga_drvr_en) begin
      state_nxt_s = IDLE;
    end else begin
      case (state_r)
        IDLE:    state_nxt_s = PREFILL;
        PREFILL: state_nxt_s = (occ_r >= OCC_W'(PREFILL_LVL)) ? STREAM : PREFILL;
        STREAM:  state_nxt_s = STREAM;
        default: state_nxt_s = IDLE;
      endcase
    end
  end

  // FSM outputs and per-cycle write/read events, all from registered state.
  always_comb begin
    not_full_s = (occ_r < OCC_W'(DEPTH));
    bffr_rdy   = (state_r == STREAM);
    wr_acc_s   = (state_r != IDLE) && wr_pxl_valid && not_full_s;
    rd_req_s   = (state_r == STREAM) && rd_pxl_req;
    pop_s      = rd_req_s && (occ_r != {OCC_W{1'b0}});
    udf_evt_s  = rd_req_s && (occ_r == {OCC_W{1'b0}});
    if (BACKPRESSURE != 0) begin
      wr_pxl_ready = (state_r != IDLE) && not_full_s;
      ovf_evt_s    = 1'b0;
    end else begin
      wr_pxl_ready = 1'b1;
      ovf_evt_s    = (state_r != IDLE) && wr_pxl_valid && !not_full_s;
    end
  end

  // Pointers, occupancy and read-valid pipeline; leaving for IDLE flushes.
  always_ff @(posedge clk_ir) begin
    if (rst_ih) begin
      wr_ptr_r   <= {AW{1'b0}};
      rd_ptr_r   <= {AW{1'b0}};
      occ_r      <= {OCC_W{1'b0}};
      rd_valid_r <= 1'b0;
      rd_hit_r   <= 1'b0;
    end else begin
      rd_valid_r <= rd_req_s;
      rd_hit_r   <= pop_s;
      if (state_nxt_s == IDLE) begin
        wr_ptr_r <= {AW{1'b0}};
        rd_ptr_r <= {AW{1'b0}};
        occ_r    <= {OCC_W{1'b0}};
      end else begin
        if (wr_acc_s) begin
          wr_ptr_r <= wr_ptr_r + AW'(1);
        end
        if (pop_s) begin
          rd_ptr_r <= rd_ptr_r + AW'(1);
        end
        case ({wr_acc_s, pop_s})
          2'b10:   occ_r <= occ_r + OCC_W'(1);
          2'b01:   occ_r <= occ_r - OCC_W'(1);
          default: occ_r <= occ_r;
        endcase
      end
    end
  end

  // Sticky status: a set event beats a simultaneous clear.
  always_ff @(posedge clk_ir) begin
    if (rst_ih) begin
      ovf_r <= 1'b0;
      udf_r <= 1'b0;
    end else begin
      if (ovf_evt_s) begin
        ovf_r <= 1'b1;
      end else if (sts_clr) begin
        ovf_r <= 1'b0;
      end
      if (udf_evt_s) begin
        udf_r <= 1'b1;
      end else if (sts_clr) begin
        udf_r <= 1'b0;
      end
    end
  end

  syn_vga_line_bffr_ram #(
    .PXL_W (PXL_W),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk_ir  (clk_ir),
    .wr_en   (wr_acc_s),
    .wr_addr (wr_ptr_r),
    .wr_data (wr_pxl_data),
    .rd_en   (pop_s),
    .rd_addr (rd_ptr_r),
    .rd_data (ram_q_s)
  );

  assign rd_pxl_valid   = rd_valid_r;
  assign rd_pxl_data    = rd_hit_r ? ram_q_s : BLANK_PXL;
  assign bffr_occ       = occ_r;
  assign bffr_overflow  = ovf_r;
  assign bffr_underflow = udf_r;

endmodule

// File: tb/tb_syn_vga_line_bffr.sv
// Directed self-checking bench: default build plus two DEPTH=4 builds
// covering both backpressure modes.
module tb_syn_vga_line_bffr;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instance A: defaults (DEPTH=1024, PREFILL_LVL=640, BACKPRESSURE=1)
  logic        a_en = 1'b0, a_wv = 1'b0, a_req = 1'b0, a_clr = 1'b0;
  logic [15:0] a_wd = 16'h0000;
  logic        a_wr, a_rv, a_rdy, a_ovf, a_udf;
  logic [15:0] a_rd;
  logic [10:0] a_occ;

  // Instance B: DEPTH=4, PREFILL_LVL=4, BACKPRESSURE=0
  logic        b_en = 1'b0, b_wv = 1'b0, b_req = 1'b0, b_clr = 1'b0;
  logic [15:0] b_wd = 16'h0000;
  logic        b_wr, b_rv, b_rdy, b_ovf, b_udf;
  logic [15:0] b_rd;
  logic [2:0]  b_occ;

  // Instance C: DEPTH=4, PREFILL_LVL=4, BACKPRESSURE=1
  logic        c_en = 1'b0, c_wv = 1'b0, c_req = 1'b0, c_clr = 1'b0;
  logic [15:0] c_wd = 16'h0000;
  logic        c_wr, c_rv, c_rdy, c_ovf, c_udf;
  logic [15:0] c_rd;
  logic [2:0]  c_occ;

  syn_vga_line_bffr u_dut_a (
    .clk_ir(clk), .rst_ih(rst), .vga_drvr_en(a_en),
    .wr_pxl_valid(a_wv), .wr_pxl_data(a_wd), .wr_pxl_ready(a_wr),
    .rd_pxl_req(a_req), .rd_pxl_valid(a_rv), .rd_pxl_data(a_rd),
    .bffr_rdy(a_rdy), .bffr_occ(a_occ), .bffr_overflow(a_ovf),
    .bffr_underflow(a_udf), .sts_clr(a_clr)
  );

  syn_vga_line_bffr #(.DEPTH(4), .PREFILL_LVL(4), .BACKPRESSURE(0)) u_dut_b (
    .clk_ir(clk), .rst_ih(rst), .vga_drvr_en(b_en),
    .wr_pxl_valid(b_wv), .wr_pxl_data(b_wd), .wr_pxl_ready(b_wr),
    .rd_pxl_req(b_req), .rd_pxl_valid(b_rv), .rd_pxl_data(b_rd),
    .bffr_rdy(b_rdy), .bffr_occ(b_occ), .bffr_overflow(b_ovf),
    .bffr_underflow(b_udf), .sts_clr(b_clr)
  );

  syn_vga_line_bffr #(.DEPTH(4), .PREFILL_LVL(4), .BACKPRESSURE(1)) u_dut_c (
    .clk_ir(clk), .rst_ih(rst), .vga_drvr_en(c_en),
    .wr_pxl_valid(c_wv), .wr_pxl_data(c_wd), .wr_pxl_ready(c_wr),
    .rd_pxl_req(c_req), .rd_pxl_valid(c_rv), .rd_pxl_data(c_rd),
    .bffr_rdy(c_rdy), .bffr_occ(c_occ), .bffr_overflow(c_ovf),
    .bffr_underflow(c_udf), .sts_clr(c_clr)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tick();
    tick();
    check_val("a_rst_occ", 32'(a_occ), 32'd0);
    check_val("a_rst_rdy", 32'(a_rdy), 32'd0);
    check_val("a_rst_rv", 32'(a_rv), 32'd0);
    check_val("a_rst_rd", 32'(a_rd), 32'h0000);
    check_val("a_rst_flags", 32'({a_ovf, a_udf}), 32'd0);
    check_val("a_rst_wready", 32'(a_wr), 32'd0);
    check_val("b_rst_wready", 32'(b_wr), 32'd1);
    check_val("c_rst_wready", 32'(c_wr), 32'd0);
    rst = 1'b0;

    // Prefill 640 pixels 0..639
    a_en = 1'b1;
    tick();
    check_val("a_prefill_wready", 32'(a_wr), 32'd1);
    for (int i = 0; i < 640; i++) begin
      a_wv = 1'b1;
      a_wd = 16'(i);
      tick();
    end
    a_wv = 1'b0;
    check_val("a_occ_640", 32'(a_occ), 32'd640);
    check_val("a_rdy_not_yet", 32'(a_rdy), 32'd0);
    tick();
    check_val("a_rdy_rise", 32'(a_rdy), 32'd1);
    check_val("a_flags_clean", 32'({a_ovf, a_udf}), 32'd0);

    // Stream out in order, one cycle latency
    for (int i = 0; i < 640; i++) begin
      a_req = 1'b1;
      tick();
      check_val("a_stream_rv", 32'(a_rv), 32'd1);
      check_val("a_stream_data", 32'(a_rd), 32'(i));
    end
    a_req = 1'b0;
    check_val("a_drained_occ", 32'(a_occ), 32'd0);
    tick();
    check_val("a_idle_rv", 32'(a_rv), 32'd0);

    // Underflow: three requests on empty buffer
    for (int k = 0; k < 3; k++) begin
      a_req = 1'b1;
      tick();
      check_val("a_udf_rv", 32'(a_rv), 32'd1);
      check_val("a_udf_data", 32'(a_rd), 32'h0000);
      check_val("a_udf_flag", 32'(a_udf), 32'd1);
    end
    a_req = 1'b0;
    tick();
    check_val("a_udf_stays_stream", 32'(a_rdy), 32'd1);
    a_clr = 1'b1;
    tick();
    a_clr = 1'b0;
    check_val("a_udf_cleared", 32'(a_udf), 32'd0);

    // Set underflow again, then load 100 pixels
    a_req = 1'b1;
    tick();
    a_req = 1'b0;
    for (int i = 0; i < 100; i++) begin
      a_wv = 1'b1;
      a_wd = 16'(1000 + i);
      tick();
    end
    a_wv = 1'b0;
    check_val("a_occ_100", 32'(a_occ), 32'd100);

    // Drop enable together with a read: in-flight read completes, then flush
    a_en  = 1'b0;
    a_req = 1'b1;
    tick();
    a_req = 1'b0;
    check_val("a_inflight_rv", 32'(a_rv), 32'd1);
    check_val("a_inflight_data", 32'(a_rd), 32'd1000);
    check_val("a_flush_occ", 32'(a_occ), 32'd0);
    check_val("a_flush_rdy", 32'(a_rdy), 32'd0);
    check_val("a_flush_wready", 32'(a_wr), 32'd0);
    check_val("a_flush_udf_kept", 32'(a_udf), 32'd1);
    a_en = 1'b1;
    tick();
    check_val("a_reen_wready", 32'(a_wr), 32'd1);
    check_val("a_reen_occ", 32'(a_occ), 32'd0);
    for (int i = 0; i < 639; i++) begin
      a_wv = 1'b1;
      a_wd = 16'(i);
      tick();
    end
    a_wv = 1'b0;
    tick();
    check_val("a_reen_rdy_639", 32'(a_rdy), 32'd0);
    a_wv = 1'b1;
    tick();
    a_wv = 1'b0;
    check_val("a_reen_occ_640", 32'(a_occ), 32'd640);
    tick();
    check_val("a_reen_rdy_640", 32'(a_rdy), 32'd1);

    // Instance B: no backpressure, writes beyond full are dropped
    b_en = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) begin
      b_wv = 1'b1;
      b_wd = 16'(16'hA0 + i);
      tick();
      check_val("b_wready", 32'(b_wr), 32'd1);
    end
    b_wv = 1'b0;
    check_val("b_occ_full", 32'(b_occ), 32'd4);
    check_val("b_ovf", 32'(b_ovf), 32'd1);
    check_val("b_rdy", 32'(b_rdy), 32'd1);
    for (int i = 0; i < 4; i++) begin
      b_req = 1'b1;
      tick();
      check_val("b_rd_data", 32'(b_rd), 32'(16'hA0 + i));
    end
    b_req = 1'b0;
    check_val("b_occ_empty", 32'(b_occ), 32'd0);

    // Instance C: full with simultaneous read and write, write refused
    c_en = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      c_wv = 1'b1;
      c_wd = 16'(16'hB0 + i);
      tick();
    end
    c_wv = 1'b0;
    check_val("c_full_wready", 32'(c_wr), 32'd0);
    tick();
    check_val("c_rdy", 32'(c_rdy), 32'd1);
    c_wv  = 1'b1;
    c_wd  = 16'h00BF;
    c_req = 1'b1;
    tick();
    c_wv  = 1'b0;
    check_val("c_rw_data", 32'(c_rd), 32'h00B0);
    check_val("c_rw_occ", 32'(c_occ), 32'd3);
    check_val("c_no_ovf", 32'(c_ovf), 32'd0);
    for (int i = 1; i < 4; i++) begin
      tick();
      check_val("c_rest_data", 32'(c_rd), 32'(16'hB0 + i));
    end
    tick();
    c_req = 1'b0;
    check_val("c_refused_not_stored", 32'(c_rd), 32'h0000);
    check_val("c_udf", 32'(c_udf), 32'd1);

    // Reset while A is streaming with data buffered
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_val("a_midrst_occ", 32'(a_occ), 32'd0);
    check_val("a_midrst_rdy", 32'(a_rdy), 32'd0);
    check_val("a_midrst_udf", 32'(a_udf), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
